// File: rtl/round_ctrl.sv
// -----------------------------------------------------------------------------
// round_ctrl - game-round sequencer for the finger-dancer core
//
// Sits directly upstream of the round timer. It enables the timer (gameState),
// supplies the round length (roundTime) and clears it (timer_clr). It consumes
// the timer expiry pulse (timer_cout). It also tracks round number, score and
// lives, shortens the round as play progresses, and declares game over.
//
// Optional feature macro: ROUND_CTRL_PAUSE_EN
//   When defined, a level-sensitive 'pause' input is added. While pause=1 in
//   PLAY, the timer is frozen (gameState=0), all key/timer events are ignored
//   and the state is held. Without the macro there is no pause port.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-low reset
//   start       in   1  1-cycle pulse: begin/restart a game (IDLE/OVER only)
//   key_hit     in   1  1-cycle pulse: correct key pressed this round
//   key_miss    in   1  1-cycle pulse: wrong key pressed this round
//   timer_cout  in   1  round timer expiry
//   pause       in   1  (ROUND_CTRL_PAUSE_EN only) freeze PLAY while high
//   gameState   out  1  timer count enable; high only in PLAY
//   roundTime   out  4  current round length to the timer
//   timer_clr   out  1  1-cycle pulse: clear timer count
//   new_round   out  1  1-cycle pulse: target generator shows next key
//   round_num   out  8  rounds started this game, saturates at 255
//   score       out  8  hits this game, saturates at 255
//   lives       out  2  remaining lives
//   game_over   out  1  high while in OVER
//   state_dbg   out  3  current FSM state (IDLE=0 ARM=1 PLAY=2 JUDGE=3 OVER=4)
//
// Handshake note: there is no valid/ready flow here. Every input is a
// single-cycle event (or, for pause, a level) sampled on the rising edge.
// Every output is a register that changes on the edge entering a state.
// -----------------------------------------------------------------------------
module round_ctrl #(
    parameter int INIT_TIME       = 9,
    parameter int MIN_TIME        = 2,
    parameter int ROUNDS_PER_STEP = 4,
    parameter int START_LIVES     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_hit,
    input  logic       key_miss,
    input  logic       timer_cout,
`ifdef ROUND_CTRL_PAUSE_EN
    input  logic       pause,
`endif
    output logic       gameState,
    output logic [3:0] roundTime,
    output logic       timer_clr,
    output logic       new_round,
    output logic [7:0] round_num,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        PLAY  = 3'd2,
        JUDGE = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [3:0] INIT_T  = 4'(INIT_TIME);
    localparam logic [3:0] MIN_T   = 4'(MIN_TIME);
    localparam logic [1:0] LIVES_0 = 2'(START_LIVES);

    state_t     state, state_n;
    logic       outcome_hit, outcome_hit_n;  // result of the round being judged
    logic       game_state_n;
    logic [3:0] round_time_n;
    logic       timer_clr_n;
    logic       new_round_n;
    logic [7:0] round_num_n;
    logic [7:0] score_n;
    logic [1:0] lives_n;
    logic       game_over_n;
    logic       paused;
    logic       step_due;

`ifdef ROUND_CTRL_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // The round being judged closes a block of ROUNDS_PER_STEP rounds.
    // round_num still holds that round's number while in JUDGE.
    assign step_due  = ((int'(round_num) % ROUNDS_PER_STEP) == 0);
    assign state_dbg = state;

    always_comb begin
        state_n       = state;
        outcome_hit_n = outcome_hit;
        game_state_n  = gameState;
        round_time_n  = roundTime;
        timer_clr_n   = 1'b0;
        new_round_n   = 1'b0;
        round_num_n   = round_num;
        score_n       = score;
        lives_n       = lives;
        game_over_n   = game_over;

        case (state)
            IDLE, OVER: begin
                // A new game: reinitialise and go straight into the first ARM.
                // round_num therefore becomes 1 on this same edge.
                if (start) begin
                    state_n      = ARM;
                    score_n      = 8'd0;
                    round_num_n  = 8'd1;
                    lives_n      = LIVES_0;
                    round_time_n = INIT_T;
                    timer_clr_n  = 1'b1;
                    new_round_n  = 1'b1;
                    game_state_n = 1'b0;
                    game_over_n  = 1'b0;
                end
            end

            ARM: begin
                state_n      = PLAY;
                game_state_n = 1'b1;
            end

            PLAY: begin
                if (paused) begin
                    game_state_n = 1'b0;
                end else begin
                    game_state_n = 1'b1;
                    // key_hit wins over any simultaneous miss or expiry
                    if (key_hit) begin
                        state_n       = JUDGE;
                        outcome_hit_n = 1'b1;
                        game_state_n  = 1'b0;
                        if (score != 8'hFF) score_n = score + 8'd1;
                    end else if (key_miss || timer_cout) begin
                        state_n       = JUDGE;
                        outcome_hit_n = 1'b0;
                        game_state_n  = 1'b0;
                        if (lives != 2'd0) lives_n = lives - 2'd1;
                    end
                end
            end

            JUDGE: begin
                game_state_n = 1'b0;
                if (lives == 2'd0) begin
                    state_n     = OVER;
                    game_over_n = 1'b1;
                end else begin
                    state_n     = ARM;
                    timer_clr_n = 1'b1;
                    new_round_n = 1'b1;
                    if (round_num != 8'hFF) round_num_n = round_num + 8'd1;
                    if (outcome_hit && step_due && (roundTime > MIN_T))
                        round_time_n = roundTime - 4'd1;
                end
            end

            default: begin
                state_n      = IDLE;
                game_state_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            outcome_hit <= 1'b0;
            gameState   <= 1'b0;
            roundTime   <= INIT_T;
            timer_clr   <= 1'b0;
            new_round   <= 1'b0;
            round_num   <= 8'd0;
            score       <= 8'd0;
            lives       <= LIVES_0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_n;
            outcome_hit <= outcome_hit_n;
            gameState   <= game_state_n;
            roundTime   <= round_time_n;
            timer_clr   <= timer_clr_n;
            new_round   <= new_round_n;
            round_num   <= round_num_n;
            score       <= score_n;
            lives       <= lives_n;
            game_over   <= game_over_n;
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_round_ctrl - self-checking bench for round_ctrl
//
// The reference model below follows the game rules directly: phase numbers,
// plain integer counters with min/max arithmetic. It produces one expected
// output snapshot per clock. Snapshots go into exp_q and are popped and
// compared field by field at the following negative edge. Directed steps
// cover the documented scenarios; a randomized tail follows.
// -----------------------------------------------------------------------------
module tb_round_ctrl;

    localparam int INIT_TIME       = 9;
    localparam int MIN_TIME        = 2;
    localparam int ROUNDS_PER_STEP = 4;
    localparam int START_LIVES     = 3;
    localparam int W               = 29;

    // phase numbers used by the model (also the documented state_dbg values)
    localparam int P_IDLE = 0, P_ARM = 1, P_PLAY = 2, P_JUDGE = 3, P_OVER = 4;

    logic       clk;
    logic       reset;
    logic       start, key_hit, key_miss, timer_cout, pause;
    logic       gameState;
    logic [3:0] roundTime;
    logic       timer_clr, new_round;
    logic [7:0] round_num, score;
    logic [1:0] lives;
    logic       game_over;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];

    // behavioural model state
    int m_phase, m_time, m_round, m_score, m_lives;
    bit m_gs, m_clr, m_new, m_over, m_last_hit;

    round_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_hit    (key_hit),
        .key_miss   (key_miss),
        .timer_cout (timer_cout),
`ifdef ROUND_CTRL_PAUSE_EN
        .pause      (pause),
`endif
        .gameState  (gameState),
        .roundTime  (roundTime),
        .timer_clr  (timer_clr),
        .new_round  (new_round),
        .round_num  (round_num),
        .score      (score),
        .lives      (lives),
        .game_over  (game_over),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    task automatic push_expected();
        exp_q.push_back({3'(m_phase), m_gs, 4'(m_time), m_clr, m_new,
                         8'(m_round), 8'(m_score), 2'(m_lives), m_over});
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_gs = 0; m_time = INIT_TIME; m_clr = 0; m_new = 0;
        m_round = 0; m_score = 0; m_lives = START_LIVES; m_over = 0; m_last_hit = 0;
        exp_q.delete();
        push_expected();
    endtask

    task automatic model_new_game();
        m_score = 0; m_lives = START_LIVES; m_time = INIT_TIME; m_round = 1;
        m_clr = 1; m_new = 1; m_gs = 0; m_over = 0; m_phase = P_ARM;
    endtask

    task automatic model_step(input bit s, input bit h, input bit m, input bit c, input bit p);
        m_clr = 0;
        m_new = 0;
        case (m_phase)
            P_IDLE, P_OVER: if (s) model_new_game();
            P_ARM: begin
                m_phase = P_PLAY;
                m_gs    = 1;
            end
            P_PLAY: begin
                m_gs = !p;
                if (!p && h) begin
                    m_score    = (m_score >= 255) ? 255 : m_score + 1;
                    m_last_hit = 1;
                    m_phase    = P_JUDGE;
                    m_gs       = 0;
                end else if (!p && (m || c)) begin
                    m_lives    = (m_lives > 0) ? m_lives - 1 : 0;
                    m_last_hit = 0;
                    m_phase    = P_JUDGE;
                    m_gs       = 0;
                end
            end
            P_JUDGE: begin
                m_gs = 0;
                if (m_lives == 0) begin
                    m_phase = P_OVER;
                    m_over  = 1;
                end else begin
                    if (m_last_hit && (m_round % ROUNDS_PER_STEP) == 0 && m_time > MIN_TIME)
                        m_time = m_time - 1;
                    m_round = (m_round >= 255) ? 255 : m_round + 1;
                    m_clr   = 1;
                    m_new   = 1;
                    m_phase = P_ARM;
                end
            end
            default: m_phase = P_IDLE;
        endcase
        push_expected();
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed=0 expected=1 entries");
        end else begin
            e = exp_q.pop_front();
            chk("state_dbg", 32'(state_dbg), 32'(e[28:26]));
            chk("gameState", 32'(gameState), 32'(e[25]));
            chk("roundTime", 32'(roundTime), 32'(e[24:21]));
            chk("timer_clr", 32'(timer_clr), 32'(e[20]));
            chk("new_round", 32'(new_round), 32'(e[19]));
            chk("round_num", 32'(round_num), 32'(e[18:11]));
            chk("score",     32'(score),     32'(e[10:3]));
            chk("lives",     32'(lives),     32'(e[2:1]));
            chk("game_over", 32'(game_over), 32'(e[0]));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cycle(input logic s, input logic h, input logic m, input logic c);
        start = s; key_hit = h; key_miss = m; timer_cout = c;
        @(posedge clk);
        model_step(s, h, m, c, pause);
        @(negedge clk);
        start = 0; key_hit = 0; key_miss = 0; timer_cout = 0;
        check_outputs();
    endtask

    // One event in PLAY, then JUDGE, then ARM back into PLAY (unless OVER).
    task automatic play_round(input logic h, input logic m, input logic c);
        cycle(1'b0, h, m, c);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        if (m_phase == P_ARM) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_outputs();
        #1;
        reset = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        start = 0; key_hit = 0; key_miss = 0; timer_cout = 0; pause = 0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_outputs();
        chk("rst_gameState", 32'(gameState), 32'd0);
        chk("rst_roundTime", 32'(roundTime), 32'd9);
        chk("rst_lives",     32'(lives),     32'd3);
        reset = 1'b1;

        // start -> ARM, then PLAY
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("arm_timer_clr", 32'(timer_clr), 32'd1);
        chk("arm_new_round", 32'(new_round), 32'd1);
        chk("arm_round_num", 32'(round_num), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("play_gameState", 32'(gameState), 32'd1);
        chk("play_roundTime", 32'(roundTime), 32'd9);
        chk("play_lives",     32'(lives),     32'd3);

        // hits on rounds 1..4: step only after the round-4 judge
        for (int i = 0; i < 3; i++) play_round(1'b1, 1'b0, 1'b0);
        chk("r3_roundTime", 32'(roundTime), 32'd9);
        play_round(1'b1, 1'b0, 1'b0);
        chk("r4_score",     32'(score),     32'd4);
        chk("r4_roundTime", 32'(roundTime), 32'd8);

        // three expiries -> game over; further hit ignored
        for (int i = 0; i < 3; i++) play_round(1'b0, 1'b0, 1'b1);
        chk("over_lives",     32'(lives),     32'd0);
        chk("over_flag",      32'(game_over), 32'd1);
        chk("over_gameState", 32'(gameState), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("over_score_held", 32'(score), 32'd4);

        // new game; hit and expiry together count as a hit
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        play_round(1'b1, 1'b0, 1'b1);
        chk("hit_cout_score", 32'(score), 32'd1);
        chk("hit_cout_lives", 32'(lives), 32'd3);

        // through round 32: roundTime floors at MIN_TIME
        for (int i = 0; i < 31; i++) play_round(1'b1, 1'b0, 1'b0);
        chk("floor_roundTime", 32'(roundTime), 32'd2);

        // long run of hits: score and round_num saturate
        for (int i = 0; i < 230; i++) play_round(1'b1, 1'b0, 1'b0);
        chk("sat_score",     32'(score),     32'd255);
        chk("sat_round_num", 32'(round_num), 32'd255);
        chk("sat_roundTime", 32'(roundTime), 32'd2);

        // misses until over (bounded), then restart reinitialises
        for (int i = 0; i < 6 && m_phase != P_OVER; i++) play_round(1'b0, 1'b1, 1'b0);
        chk("miss_over", 32'(game_over), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_score",     32'(score),     32'd0);
        chk("restart_lives",     32'(lives),     32'd3);
        chk("restart_roundTime", 32'(roundTime), 32'd9);
        chk("restart_over",      32'(game_over), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        play_round(1'b1, 1'b0, 1'b0);

        // asynchronous reset in PLAY
        apply_reset();
        chk("midrst_gameState", 32'(gameState), 32'd0);
        chk("midrst_score",     32'(score),     32'd0);
        chk("midrst_lives",     32'(lives),     32'd3);
        chk("midrst_state",     32'(state_dbg), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ROUND_CTRL_PAUSE_EN
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, (i == 1));
            chk("pause_gameState", 32'(gameState), 32'd0);
        end
        chk("pause_lives", 32'(lives),     32'd3);
        chk("pause_state", 32'(state_dbg), 32'd2);
        pause = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_gameState", 32'(gameState), 32'd1);
`endif

        // randomized tail checked against the model
        for (int i = 0; i < 400; i++) begin
`ifdef ROUND_CTRL_PAUSE_EN
            pause = ($urandom_range(0, 7) == 0);
`endif
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
        end
        pause = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
